pa_soc_wbu: RTL

// - Writeback unit: the single producer of the register-file write port (rd_addr/rd_data/rd_data_vld).
// - Merges ALU results (single cycle) and load returns (multi-cycle) onto that one port.
// - Tracks one outstanding load and reorders data lanes for it.
// - Protects ordering with a one-entry scoreboard; sits between EXU/LSU and the register file.

---
 rtl/pa_soc_wbu_pkg.sv | 21 ++
 rtl/pa_soc_wbu_ldext.sv | 32 +++
 rtl/pa_soc_wbu.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pa_soc_wbu_pkg.sv
// Shared FSM encodings and load-size codes for the writeback unit.
package pa_soc_wbu_pkg;

  typedef enum logic {
    WBU_IDLE = 1'b0,
    WBU_WAIT = 1'b1
  } wbu_state_e;

  localparam logic [1:0] LD_SIZE_BYTE = 2'd0;
  localparam logic [1:0] LD_SIZE_HALF = 2'd1;
  localparam logic [1:0] LD_SIZE_WORD = 2'd2;
  localparam logic [1:0] LD_SIZE_RSVD = 2'd3;

  // Reserved size, odd halfword or unaligned word.
  function automatic logic ld_bad(input logic [1:0] size, input logic [1:0] lo);
    return (size == LD_SIZE_RSVD) ||
           (size == LD_SIZE_HALF && lo[0]) ||
           (size == LD_SIZE_WORD && lo != 2'd0);
  endfunction

endpackage

// File: rtl/pa_soc_wbu_ldext.sv
// Load lane extraction: selects byte/half/word from a little-endian word and
// sign- or zero-extends it; flags illegal size/alignment combinations.
module pa_soc_wbu_ldext
  import pa_soc_wbu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [1:0]        lo,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word[{lo, 3'b000} +: 8];
  assign half_lane = word[{lo[1], 4'b0000} +: 16];
  assign err       = ld_bad(size, lo);

  always_comb begin
    data = word;
    case (size)
      LD_SIZE_BYTE: data = {{(DATA_W-8){sign & byte_lane[7]}}, byte_lane};
      LD_SIZE_HALF: data = {{(DATA_W-16){sign & half_lane[15]}}, half_lane};
      default:      data = word;
    endcase
  end

endmodule

// File: rtl/pa_soc_wbu.sv
// Writeback unit: merges ALU results and one outstanding load onto the register-file
// write port. Define PA_SOC_WBU_FWD_EN to add the forwarding/hazard ports.
module pa_soc_wbu
  import pa_soc_wbu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              exu_vld,
  output logic              exu_rdy,
  input  logic [REG_AW-1:0] exu_rd_addr,
  input  logic [DATA_W-1:0] exu_rd_data,
  input  logic              ld_req_vld,
  output logic              ld_req_rdy,
  input  logic [REG_AW-1:0] ld_rd_addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_sign,
  input  logic [1:0]        ld_addr_lo,
  input  logic              mem_rsp_vld,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              ld_err,
`ifdef PA_SOC_WBU_FWD_EN
  input  logic [REG_AW-1:0] fwd_rs1_addr,
  input  logic [REG_AW-1:0] fwd_rs2_addr,
  output logic              fwd_rs1_hit,
  output logic              fwd_rs2_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              hazard_o,
`endif
  output logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_vld
);

  wbu_state_e        state_reg, state_next;
  logic [REG_AW-1:0] pend_rd_reg;
  logic [1:0]        pend_size_reg, pend_lo_reg;
  logic              pend_sign_reg;
  logic              capture;

  logic [REG_AW-1:0] rd_addr_reg, rd_addr_next;
  logic [DATA_W-1:0] rd_data_reg, rd_data_next;
  logic              rd_vld_reg, rd_vld_next;
  logic              ld_err_reg, ld_err_next;

  // The extractor checks the incoming request in IDLE and decodes the response in WAIT.
  logic              in_wait;
  logic [1:0]        ext_size, ext_lo;
  logic              ext_sign, ext_err;
  logic [DATA_W-1:0] ext_data;

  assign in_wait  = (state_reg == WBU_WAIT);
  assign ext_size = in_wait ? pend_size_reg : ld_size;
  assign ext_lo   = in_wait ? pend_lo_reg   : ld_addr_lo;
  assign ext_sign = in_wait ? pend_sign_reg : ld_sign;

  pa_soc_wbu_ldext #(.DATA_W(DATA_W)) u_ldext (
    .size (ext_size),
    .sign (ext_sign),
    .lo   (ext_lo),
    .word (mem_rsp_data),
    .data (ext_data),
    .err  (ext_err)
  );

  always_comb begin
    state_next   = state_reg;
    exu_rdy      = 1'b1;
    ld_req_rdy   = 1'b0;
    capture      = 1'b0;
    rd_addr_next = rd_addr_reg;
    rd_data_next = rd_data_reg;
    rd_vld_next  = 1'b0;
    ld_err_next  = 1'b0;
    case (state_reg)
      WBU_IDLE: begin
        ld_req_rdy = 1'b1;
        if (ld_req_vld) begin
          if (ext_err) begin
            ld_err_next = 1'b1;
          end else begin
            capture    = 1'b1;
            state_next = WBU_WAIT;
          end
        end
      end
      WBU_WAIT: begin
        if (mem_rsp_vld) begin
          exu_rdy      = 1'b0;
          state_next   = WBU_IDLE;
          rd_vld_next  = (pend_rd_reg != '0);
          rd_addr_next = pend_rd_reg;
          rd_data_next = ext_data;
        end else if (pend_rd_reg != '0 && exu_rd_addr == pend_rd_reg) begin
          exu_rdy = 1'b0;
        end
      end
      default: state_next = WBU_IDLE;
    endcase
    if (exu_vld && exu_rdy) begin
      rd_vld_next  = (exu_rd_addr != '0);
      rd_addr_next = exu_rd_addr;
      rd_data_next = exu_rd_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= WBU_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_rd_reg   <= '0;
      pend_size_reg <= '0;
      pend_lo_reg   <= '0;
      pend_sign_reg <= 1'b0;
      rd_addr_reg   <= '0;
      rd_data_reg   <= '0;
      rd_vld_reg    <= 1'b0;
      ld_err_reg    <= 1'b0;
    end else begin
      if (capture) begin
        pend_rd_reg   <= ld_rd_addr;
        pend_size_reg <= ld_size;
        pend_lo_reg   <= ld_addr_lo;
        pend_sign_reg <= ld_sign;
      end
      rd_addr_reg <= rd_addr_next;
      rd_data_reg <= rd_data_next;
      rd_vld_reg  <= rd_vld_next;
      ld_err_reg  <= ld_err_next;
    end
  end

  assign rd_addr     = rd_addr_reg;
  assign rd_data     = rd_data_reg;
  assign rd_data_vld = rd_vld_reg;
  assign ld_err      = ld_err_reg;

`ifdef PA_SOC_WBU_FWD_EN
  logic [REG_AW-1:0] fwd_addr [2];
  logic [1:0]        fwd_hit, pend_hit;

  assign fwd_addr[0] = fwd_rs1_addr;
  assign fwd_addr[1] = fwd_rs2_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_hit[gi]  = rd_vld_reg && (rd_addr_reg != '0) && (fwd_addr[gi] == rd_addr_reg);
    assign pend_hit[gi] = in_wait && (pend_rd_reg != '0) && (fwd_addr[gi] == pend_rd_reg);
  end

  assign fwd_rs1_hit = fwd_hit[0];
  assign fwd_rs2_hit = fwd_hit[1];
  assign fwd_data    = rd_data_reg;
  assign hazard_o    = |pend_hit;
`endif

endmodule
